// File: rtl/feistel_decrypt_core.sv
// Iterative Feistel cipher core, one round per clock, selectable encrypt/decrypt per block.
// Blocks enter and leave over valid/ready handshakes; results are held in DONE until taken.
`timescale 1ns/1ps
module feistel_decrypt_core #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_block,
  input  logic [DATA_W-1:0] in_key,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_block,
  output logic              busy
);

  localparam int H  = DATA_W / 2;
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_key;
  logic              r_mode;
  logic [CW-1:0]     r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_block;
  logic              r_busy;

  logic [H-1:0]      w_key_sel;
  logic [H-1:0]      w_rk;
  logic [H-1:0]      w_f;
  logic [DATA_W-1:0] w_next;
  logic              w_last;

  function automatic logic [H-1:0] rotl(input logic [H-1:0] x, input int unsigned s);
    logic [2*H-1:0] w;
    w = {x, x} << (s % H);
    return w[2*H-1:H];
  endfunction

  function automatic logic [H-1:0] round_f(input logic [H-1:0] x, input logic [H-1:0] k);
    return rotl(x ^ k, 32'd3) + k;
  endfunction

  // Round key, round function and next half-block pair for the current counter value
  always_comb begin
    w_key_sel = '0;
    w_f       = '0;
    w_next    = r_data;
    if (r_cnt[0] == 1'b0) begin
      w_key_sel = r_key[DATA_W-1:H];
    end else begin
      w_key_sel = r_key[H-1:0];
    end
    w_rk = rotl(w_key_sel, 32'(r_cnt));
    if (r_mode) begin
      w_f    = round_f(r_data[H-1:0], w_rk);
      w_next = {r_data[H-1:0], r_data[DATA_W-1:H] ^ w_f};
    end else begin
      w_f    = round_f(r_data[DATA_W-1:H], w_rk);
      w_next = {r_data[H-1:0] ^ w_f, r_data[DATA_W-1:H]};
    end
    if (r_mode) begin
      w_last = (r_cnt == LAST_CNT);
    end else begin
      w_last = (r_cnt == '0);
    end
  end

  // Control FSM with all handshake outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_key       <= '0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_block <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= in_block;
            r_key      <= in_key;
            r_mode     <= in_mode;
            r_cnt      <= in_mode ? '0 : LAST_CNT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_data <= w_next;
          if (w_last) begin
            r_out_block <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_mode) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;
  assign busy      = r_busy;

endmodule

// File: tb/tb_feistel_decrypt_core.sv
// Scoreboard bench: a 16-bit/1-round instance for hand vectors and a default 64-bit/8-round
// instance for round trips, backpressure and reset abort.
`timescale 1ns/1ps
module tb_feistel_decrypt_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic        s_iv, s_ir, s_mode, s_ov, s_or, s_busy;
  logic [15:0] s_ib, s_key, s_ob;
  logic        b_iv, b_ir, b_mode, b_ov, b_or, b_busy;
  logic [63:0] b_ib, b_key, b_ob;

  feistel_decrypt_core #(.DATA_W(16), .ROUNDS(1)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_ir), .in_block(s_ib),
    .in_key(s_key), .in_mode(s_mode), .out_valid(s_ov), .out_ready(s_or),
    .out_block(s_ob), .busy(s_busy));

  feistel_decrypt_core #(.DATA_W(64), .ROUNDS(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir), .in_block(b_ib),
    .in_key(b_key), .in_mode(b_mode), .out_valid(b_ov), .out_ready(b_or),
    .out_block(b_ob), .busy(b_busy));

  typedef struct {
    logic [63:0] data;
    int          acc;
  } exp_t;

  exp_t s_q[$];
  exp_t b_q[$];
  int   s_hs = 0;
  int   b_hs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event-missing required=event at cycle %0d", name, cyc);
  endtask

  // Independent cipher model written bit by bit from the algorithm description
  function automatic logic [63:0] m_rotl(input logic [63:0] x, input int s, input int h);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < h; j++) r[(j + s) % h] = x[j];
    return r;
  endfunction

  function automatic logic [63:0] m_f(input logic [63:0] x, input logic [63:0] k, input int h);
    logic [63:0] mask;
    mask = (64'd1 << h) - 64'd1;
    return (m_rotl(x ^ k, 3 % h, h) + k) & mask;
  endfunction

  function automatic logic [63:0] m_cipher(input logic [63:0] blk, input logic [63:0] key,
                                           input int h, input int rounds, input bit enc);
    logic [63:0] mask, l, r, k0, k1, rk, t;
    mask = (64'd1 << h) - 64'd1;
    l  = (blk >> h) & mask;
    r  = blk & mask;
    k0 = (key >> h) & mask;
    k1 = key & mask;
    if (enc) begin
      for (int i = 0; i < rounds; i++) begin
        rk = m_rotl((i % 2 == 0) ? k0 : k1, i % h, h);
        t  = l ^ m_f(r, rk, h);
        l  = r;
        r  = t;
      end
    end else begin
      for (int i = rounds - 1; i >= 0; i--) begin
        rk = m_rotl((i % 2 == 0) ? k0 : k1, i % h, h);
        t  = r ^ m_f(l, rk, h);
        r  = l;
        l  = t;
      end
    end
    return (l << h) | r;
  endfunction

  // Monitor for the small instance
  initial begin
    bit seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 1'b0;
      end else begin
        if (s_ov && !seen) begin
          seen = 1'b1;
          if (s_q.size() > 0) check("lat_small", 64'(cyc - s_q[0].acc), 64'd1);
        end
        if (s_ov && s_or) begin
          if (s_q.size() == 0) fail_now("extra_small");
          else begin
            e = s_q.pop_front();
            check("data_small", {48'd0, s_ob}, e.data);
          end
          seen = 1'b0;
          s_hs++;
        end
      end
    end
  end

  // Monitor for the default instance
  initial begin
    bit seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 1'b0;
      end else begin
        if (b_ov && !seen) begin
          seen = 1'b1;
          if (b_q.size() > 0) check("lat_big", 64'(cyc - b_q[0].acc), 64'd8);
        end
        if (b_ov && b_or) begin
          if (b_q.size() == 0) fail_now("extra_big");
          else begin
            e = b_q.pop_front();
            check("data_big", b_ob, e.data);
          end
          seen = 1'b0;
          b_hs++;
        end
      end
    end
  end

  task automatic send(input bit big, input logic [63:0] blk, input logic [63:0] key,
                      input bit mode, input logic [63:0] expv);
    int n;
    exp_t e;
    n = 0;
    while (!(big ? b_ir : s_ir) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now(big ? "accept_timeout_big" : "accept_timeout_small");
    if (big) begin
      b_iv = 1'b1; b_ib = blk; b_key = key; b_mode = mode;
    end else begin
      s_iv = 1'b1; s_ib = blk[15:0]; s_key = key[15:0]; s_mode = mode;
    end
    @(posedge clk); #1;
    e.data = expv;
    e.acc  = cyc;
    if (big) begin
      b_q.push_back(e);
      b_iv = 1'b0;
    end else begin
      s_q.push_back(e);
      s_iv = 1'b0;
    end
  endtask

  task automatic drain(input bit big);
    int n;
    n = 0;
    while (((big ? b_q.size() : s_q.size()) != 0 || !(big ? b_ir : s_ir)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now(big ? "drain_timeout_big" : "drain_timeout_small");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_in_ready"}, {63'd0, s_ir}, 64'd1);
    check({tag, "_s_out_valid"}, {63'd0, s_ov}, 64'd0);
    check({tag, "_s_out_block"}, {48'd0, s_ob}, 64'd0);
    check({tag, "_s_busy"}, {63'd0, s_busy}, 64'd0);
    check({tag, "_b_in_ready"}, {63'd0, b_ir}, 64'd1);
    check({tag, "_b_out_valid"}, {63'd0, b_ov}, 64'd0);
    check({tag, "_b_out_block"}, b_ob, 64'd0);
    check({tag, "_b_busy"}, {63'd0, b_busy}, 64'd0);
  endtask

  task automatic reset_with_noise(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      s_iv = 1'($urandom); s_ib = 16'($urandom); s_key = 16'($urandom);
      s_mode = 1'($urandom); s_or = 1'($urandom);
      b_iv = 1'($urandom); b_ib = {$urandom, $urandom}; b_key = {$urandom, $urandom};
      b_mode = 1'($urandom); b_or = 1'($urandom);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    s_iv = 1'b0; b_iv = 1'b0; s_or = 1'b1; b_or = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] blk, key, enc, other;
    int n, hs0;
    s_iv = 1'b0; s_ib = '0; s_key = '0; s_mode = 1'b0; s_or = 1'b1;
    b_iv = 1'b0; b_ib = '0; b_key = '0; b_mode = 1'b0; b_or = 1'b1;
    reset = 1'b0;
    reset_with_noise(5);
    @(posedge clk); #1;

    // Hand vectors on the 16-bit, single-round instance
    send(1'b0, 64'h0102, 64'h0000, 1'b1, 64'h0211);
    drain(1'b0);
    send(1'b0, 64'h0211, 64'h0000, 1'b0, 64'h0102);
    drain(1'b0);
    for (int i = 0; i < 20; i++) begin
      blk = 64'($urandom_range(0, 65535));
      key = 64'($urandom_range(0, 65535));
      enc = m_cipher(blk, key, 8, 1, 1'b1);
      send(1'b0, blk, key, 1'b1, enc);
      drain(1'b0);
      send(1'b0, enc, key, 1'b0, blk);
      drain(1'b0);
    end

    // Round trips on the default instance
    for (int i = 0; i < 1000; i++) begin
      blk = {$urandom, $urandom};
      key = {$urandom, $urandom};
      enc = m_cipher(blk, key, 32, 8, 1'b1);
      send(1'b1, blk, key, 1'b1, enc);
      drain(1'b1);
      send(1'b1, enc, key, 1'b0, blk);
      drain(1'b1);
    end

    // Backpressure held for 20 cycles in DONE
    blk = 64'h0123_4567_89AB_CDEF;
    key = 64'h0F1E_2D3C_4B5A_6978;
    enc = m_cipher(blk, key, 32, 8, 1'b1);
    b_or = 1'b0;
    send(1'b1, blk, key, 1'b1, enc);
    n = 0;
    while (!b_ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_ov) fail_now("bp_out_valid_rise");
    @(posedge clk); #1;
    other = ~blk;
    b_iv = 1'b1; b_ib = other; b_mode = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("bp_block", b_ob, enc);
      check("bp_valid", {63'd0, b_ov}, 64'd1);
      check("bp_in_ready", {63'd0, b_ir}, 64'd0);
    end
    @(posedge clk); #1;
    b_iv = 1'b0;
    hs0 = b_hs;
    b_or = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_transfers", 64'(b_hs - hs0), 64'd1);
    check("bp_in_ready_after", {63'd0, b_ir}, 64'd1);
    drain(1'b1);

    // Reset during round 4 of 8 aborts the block
    blk = 64'hDEAD_BEEF_CAFE_F00D;
    key = 64'h1357_9BDF_2468_ACE0;
    send(1'b1, blk, key, 1'b1, m_cipher(blk, key, 32, 8, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    b_q.delete();
    s_q.delete();
    reset_with_noise(4);
    repeat (15) begin
      @(negedge clk);
      check("abort_no_valid", {63'd0, b_ov}, 64'd0);
    end
    @(posedge clk); #1;
    blk = 64'h0011_2233_4455_6677;
    key = 64'h8899_AABB_CCDD_EEFF;
    enc = m_cipher(blk, key, 32, 8, 1'b0);
    send(1'b1, blk, key, 1'b0, enc);
    drain(1'b1);
    send(1'b1, enc, key, 1'b1, blk);
    drain(1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
